// File: rtl/linear_interp_up.sv
// Linear interpolating upsampler (x2**LOG2_L) with a one-deep pending input register.
// Optional macro LI_ROUND_EN: round half up on intermediate outputs instead of floor.
module linear_interp_up #(
  parameter int WIDTH      = 18,
  parameter int LOG2_L     = 3,
  parameter int OUT_PERIOD = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] LI_in,
  input  logic             ready_in,
  output logic [WIDTH-1:0] LI_out,
  output logic             ready_out,
  output logic             overrun,
  output logic             busy
);
  localparam int L  = 1 << LOG2_L;
  localparam int AW = WIDTH + LOG2_L + 1;
  localparam int CW = (OUT_PERIOD > 1) ? $clog2(OUT_PERIOD) : 1;
  localparam int KW = LOG2_L + 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_t;
  state_t r_state, w_state_nxt;

  logic signed [WIDTH-1:0] r_x_prev, r_x_new, r_pend;
  logic                    r_pend_v;
  logic signed [WIDTH:0]   r_delta;
  logic signed [AW-1:0]    r_acc;
  logic [CW-1:0]           r_cnt;
  logic [KW-1:0]           r_k;

  logic                    w_fire, w_last, w_take_pend, w_start;
  logic signed [WIDTH-1:0] w_start_val;
  logic signed [AW-1:0]    w_acc_nxt, w_acc_rnd;

  assign w_fire      = (r_state == S_RUN) && (r_cnt == '0);
  assign w_last      = w_fire && (r_k == KW'(L - 1));
  assign w_take_pend = w_last && r_pend_v;
  assign w_start     = ((r_state == S_IDLE) && ready_in) || (w_last && (r_pend_v || ready_in));
  assign w_start_val = w_take_pend ? r_pend : LI_in;
  assign busy        = (r_state != S_IDLE);

  assign w_acc_nxt = r_acc + {{(AW-WIDTH-1){r_delta[WIDTH]}}, r_delta};
`ifdef LI_ROUND_EN
  assign w_acc_rnd = w_acc_nxt + AW'(2 ** (LOG2_L - 1));
`else
  assign w_acc_rnd = w_acc_nxt;
`endif

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (ready_in) w_state_nxt = S_LOAD;
      S_LOAD: w_state_nxt = S_RUN;
      S_RUN:  if (w_last) w_state_nxt = w_start ? S_LOAD : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      LI_out    <= '0;
      ready_out <= 1'b0;
      overrun   <= 1'b0;
      r_x_prev  <= '0;
      r_x_new   <= '0;
      r_pend    <= '0;
      r_pend_v  <= 1'b0;
      r_delta   <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_k       <= '0;
    end else begin
      ready_out <= 1'b0;
      if (w_start) r_x_new <= w_start_val;

      // Burst-ending edge frees the pending slot for a sample arriving on the same edge.
      if (w_take_pend) begin
        r_pend_v <= ready_in;
        if (ready_in) r_pend <= LI_in;
      end else if (ready_in && (r_state != S_IDLE) && !w_last) begin
        if (!r_pend_v) begin
          r_pend_v <= 1'b1;
          r_pend   <= LI_in;
        end else begin
          overrun <= 1'b1;
        end
      end

      if (r_state == S_LOAD) begin
        r_delta <= {r_x_new[WIDTH-1], r_x_new} - {r_x_prev[WIDTH-1], r_x_prev};
        r_acc   <= {r_x_prev[WIDTH-1], r_x_prev, {LOG2_L{1'b0}}};
        r_k     <= '0;
        r_cnt   <= CW'(OUT_PERIOD - 1);
      end else if (r_state == S_RUN) begin
        if (w_fire) begin
          r_acc     <= w_acc_nxt;
          r_k       <= r_k + 1'b1;
          LI_out    <= w_acc_rnd[WIDTH+LOG2_L-1:LOG2_L];
          ready_out <= 1'b1;
          r_cnt     <= CW'(OUT_PERIOD - 1);
          if (w_last) r_x_prev <= r_x_new;
        end else begin
          r_cnt <= r_cnt - 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_linear_interp_up.sv
// Bench for linear_interp_up: cycle-level behavioural model plus directed literal checks.
module tb_linear_interp_up;
  localparam int W = 18, LG = 3, OP = 4, L = 8;

  logic          clock = 0;
  logic          reset = 0;
  logic [W-1:0]  LI_in = '0;
  logic          ready_in = 0;
  logic [W-1:0]  LI_out;
  logic          ready_out, overrun, busy;

  linear_interp_up #(.WIDTH(W), .LOG2_L(LG), .OUT_PERIOD(OP)) dut (
    .clock(clock), .reset(reset), .LI_in(LI_in), .ready_in(ready_in),
    .LI_out(LI_out), .ready_out(ready_out), .overrun(overrun), .busy(busy));

  always #5 clock = ~clock;

  int checks = 0, errors = 0;
  function automatic void chk(string n, longint a, longint e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s got %0d want %0d (t=%0t)", n, a, e, $time);
    end
  endfunction

  // Behavioural model: tracks burst windows, pending slot and scheduled outputs.
  typedef struct { int e; longint v; } ev_t;
  ev_t    exp_q[$];
  int     cyc = 0, fend = 0;
  bit     armed = 0, act = 0, pv = 0, ovr = 0;
  longint xp = 0, pval = 0, lastout = 0;

  function automatic longint fdiv(longint a, longint b);
    return (a >= 0) ? a / b : -((-a + b - 1) / b);
  endfunction

  function automatic longint interp(longint a, longint b, int k);
    longint num;
    num = a * L + k * (b - a);
`ifdef LI_ROUND_EN
    return fdiv(num + L / 2, L);
`else
    return fdiv(num, L);
`endif
  endfunction

  task automatic start_burst(int e, longint x);
    act  = 1;
    fend = e + 1 + L * OP;
    for (int k = 1; k <= L; k++) exp_q.push_back('{e + 1 + k * OP, interp(xp, x, k)});
    xp = x;
  endtask

  always @(posedge clock) begin
    cyc++;
    if (reset) begin
      armed = 1; act = 0; pv = 0; ovr = 0; xp = 0; lastout = 0;
      exp_q.delete();
    end else begin
      if (act && cyc == fend) act = 0;
      if (!act && pv) begin
        start_burst(cyc, pval);
        pv = 0;
      end
      if (ready_in) begin
        if (!act)      start_burst(cyc, longint'($signed(LI_in)));
        else if (!pv) begin pv = 1; pval = longint'($signed(LI_in)); end
        else           ovr = 1;
      end
    end
  end

  longint seen[$];
  int     seen_cyc[$];
  bit     exp_rdy;

  always @(negedge clock) begin
    if (armed) begin
      exp_rdy = (exp_q.size() > 0) && (exp_q[0].e == cyc);
      chk("ready_out", ready_out, exp_rdy);
      if (exp_rdy) begin
        chk("LI_out", longint'($signed(LI_out)), exp_q[0].v);
        lastout = exp_q[0].v;
        void'(exp_q.pop_front());
      end else begin
        chk("LI_out_hold", longint'($signed(LI_out)), lastout);
      end
      chk("busy", busy, act);
      chk("overrun", overrun, ovr);
      if (ready_out) begin
        seen.push_back(longint'($signed(LI_out)));
        seen_cyc.push_back(cyc);
      end
    end
  end

  int last_e0 = 0;

  task automatic nxt();
    @(negedge clock); #1;
  endtask

  task automatic do_reset();
    nxt(); reset = 1; ready_in = 0;
    nxt(); reset = 0;
  endtask

  task automatic strobe(int v);
    nxt(); ready_in = 1; LI_in = W'(v);
    nxt(); ready_in = 0; last_e0 = cyc;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 300) begin nxt(); n++; end
    chk("idle_timeout", busy, 0);
  endtask

  task automatic chk_seen(string n, int base, int vals[8]);
    for (int i = 0; i < 8; i++)
      chk(n, (seen.size() > base + i) ? seen[base + i] : 999999, vals[i]);
  endtask

  int t1a[8] = '{10, 20, 30, 40, 50, 60, 70, 80};
  int t1b[8] = '{70, 60, 50, 40, 30, 20, 10, 0};
`ifdef LI_ROUND_EN
  int t2a[8] = '{2, 4, 6, 8, 9, 11, 13, 15};
  int t2b[8] = '{-2, -4, -6, -7, -9, -11, -13, -15};
`else
  int t2a[8] = '{1, 3, 5, 7, 9, 11, 13, 15};
  int t2b[8] = '{-2, -4, -6, -8, -10, -12, -14, -15};
`endif
  int t6[8] = '{1, 2, 3, 4, 5, 6, 7, 8};

  initial begin
    reset = 1;
    repeat (2) nxt();
    reset = 0;
    chk("rst_LI_out", LI_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);

    // 1: ramp up then down, with latency
    seen.delete(); seen_cyc.delete();
    strobe(80); wait_idle();
    chk_seen("t1_up", 0, t1a);
    chk("t1_first_lat", seen_cyc.size() > 0 ? seen_cyc[0] - last_e0 : -1, 5);
    chk("t1_period", seen_cyc.size() > 1 ? seen_cyc[1] - seen_cyc[0] : -1, 4);
    strobe(0); wait_idle();
    chk_seen("t1_down", 8, t1b);

    // 2: rounding behaviour on non-multiples of L
    seen.delete();
    strobe(15); wait_idle();
    strobe(0); wait_idle();
    strobe(-15); wait_idle();
    chk_seen("t2_pos", 0, t2a);
    chk_seen("t2_neg", 16, t2b);

    // 3: full-scale swing
    seen.delete();
    strobe(131071); wait_idle();
    strobe(-131072); wait_idle();
    chk("t3_end", seen.size() == 16 ? seen[15] : 0, -131072);
    for (int i = 8; i < 16 && i < seen.size(); i++) begin
      chk("t3_range", (seen[i] >= -131072 && seen[i] <= 131071), 1);
      if (i > 8) chk("t3_mono", seen[i] <= seen[i-1], 1);
    end

    // 4: three strobes on consecutive clocks
    seen.delete();
    nxt(); ready_in = 1; LI_in = W'(100);
    nxt(); LI_in = W'(200);
    nxt(); LI_in = W'(300);
    nxt(); ready_in = 0;
    chk("t4_overrun", overrun, 1);
    wait_idle();
    chk("t4_count", seen.size(), 16);
    chk("t4_end1", seen.size() > 7 ? seen[7] : 0, 100);
    chk("t4_end2", seen.size() > 15 ? seen[15] : 0, 200);
    do_reset();

    // 5: strobe coincident with the final-output edge while pending is full
    seen.delete();
    strobe(10);
    strobe(40);
    begin
      int n = 0;
      while (cyc < last_e0 - 2 + 32 && n < 100) begin nxt(); n++; end
    end
    ready_in = 1; LI_in = W'(50);
    nxt(); ready_in = 0;
    wait_idle();
    chk("t5_count", seen.size(), 24);
    chk("t5_end40", seen.size() > 15 ? seen[15] : 0, 40);
    chk("t5_end50", seen.size() > 23 ? seen[23] : 0, 50);
    chk("t5_overrun", overrun, 0);

    // 6: reset mid-burst restarts from zero
    do_reset();
    seen.delete();
    strobe(80);
    begin
      int n = 0;
      while (seen.size() < 3 && n < 100) begin nxt(); n++; end
    end
    chk("t6_third", seen.size(), 3);
    reset = 1;
    nxt(); reset = 0;
    chk("t6_LI_out", LI_out, 0);
    chk("t6_ready", ready_out, 0);
    chk("t6_busy", busy, 0);
    seen.delete();
    strobe(8); wait_idle();
    chk_seen("t6_restart", 0, t6);

    repeat (3) nxt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
